pool_stream_ctrl: RTL and testbench
===================================

// Module: pool_stream_ctrl
// PURPOSE
// Frame sequencer/flow controller between the conv1 output stream and the 2x2 max-pool stage.
// Clears the pool before each frame, admits exactly IN_DIM*IN_DIM conv1 beats (6 maps in parallel per beat),
// and gates beats that complete a 2x2 window on downstream credits, so pooled outputs are never dropped.
// Counts pooled outputs, signals frame completion, and flags drain timeout and credit errors.
// PARAMETERS
// IN_DIM      28    conv1 map width/height; must be even
// OUT_CREDITS 4     downstream buffer depth in pooled vectors; reset/start value of credit counter
// TIMEOUT     64    max cycles in DRAIN waiting for the remaining pool outputs
// PORTS
// i_clk            in   1   clock
// i_rst_n          in   1   asynchronous active-low reset
// i_start          in   1   start-of-frame pulse; ignored unless state==IDLE
// o_busy           out  1   high in every state except IDLE
// o_done           out  1   one-cycle pulse in state DONE
// o_err_timeout    out  1   sticky; cleared on accepted i_start
// o_err_credit     out  1   sticky; return with credits==OUT_CREDITS; cleared on accepted i_start
// i_conv_valid     in   1   conv1 beat available
// o_conv_ready     out  1   controller accepts beat (combinational from state/counters/credits)
// o_pool_valid     out  1   = i_conv_valid & o_conv_ready; drives pool feature-valid
// o_pool_clr       out  1   synchronous clear to pool; high only in state CLR
// o_row            out  $clog2(IN_DIM)  row of next beat to accept
// o_col            out  $clog2(IN_DIM)  column of next beat to accept
// i_pool_valid     in   1   pool produced one pooled vector this cycle
// i_credit_return  in   1   downstream freed one slot
// o_credits        out  $clog2(OUT_CREDITS+1)  current credits
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, row=col=0, out_cnt=0, tmo_cnt=0, credits=OUT_CREDITS,
//   all 1-bit outputs 0.
// - FSM: IDLE -(i_start)-> CLR (exactly 1 cycle) -> STREAM -(last beat accepted)-> DRAIN
//   -(all outputs counted, or timeout)-> DONE (1 cycle) -> IDLE.
// - Accepted i_start also reloads credits=OUT_CREDITS and clears row, col, out_cnt and both error flags.
// - Beats are accepted only in STREAM.
// - A beat is producing when row[0] & col[0]; it closes a 2x2 window.
// - o_conv_ready = (state==STREAM) & (!producing | credits!=0).
// - Credit reservation:
//   - A credit is taken when a producing beat is accepted, not on i_pool_valid; the pool result follows 1 cycle later.
//   - An accepted producing beat and i_credit_return in the same cycle leave credits unchanged.
//   - A return with credits==OUT_CREDITS and no decrement that cycle: credits saturate, o_err_credit=1.
// - Counters on accept:
//   - col increments; at IN_DIM-1, col wraps to 0 and row increments.
//   - Accepting (IN_DIM-1, IN_DIM-1) moves to DRAIN; row/col wrap to 0.
// - out_cnt increments on i_pool_valid in any state except IDLE/CLR.
// - Exit condition: DRAIN exits when out_cnt+i_pool_valid == (IN_DIM/2)^2.
//   This counts the same cycle, so o_done comes 1 cycle after the final i_pool_valid.
// - i_pool_valid in IDLE/CLR is ignored.
// - Timeout: tmo_cnt counts DRAIN cycles; at TIMEOUT-1 without completion -> DONE with o_err_timeout=1.
// - Latency: o_pool_valid is same-cycle with the handshake; no data passes through this block.
// - i_start during a frame is ignored.
// - Reset mid-frame returns to IDLE; the pool is cleared again via CLR on the next start.
// - Widths: out_cnt is $clog2((IN_DIM/2)^2+1); tmo_cnt is $clog2(TIMEOUT).
// STRUCTURE
// - pool_ctrl_pkg holds:
//   - typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} pool_ctrl_state_t
//   - localparams POOL_IN_DIM=28, POOL_OUT_DIM=14, POOL_MAPS=6
// - One sub-module: pool_credit_cnt (up/down saturating credit counter + overflow flag).
// - FSM and row/col/out/timeout counters stay in this module.
// TESTING
// 1 Full frame, OUT_CREDITS=4, return every credit 2 cycles after use, conv valid held high
//   -> 784 accepts, 196 pool_valid; o_done 1 cycle after last i_pool_valid; no error flags.
// 2 No credit returns, OUT_CREDITS=2 -> accepts (1,1) and (1,3); ready=0 at row1 col5 while credits==0.
//   One return -> beat accepted on the next cycle.
// 3 Same-cycle producing accept + i_credit_return at credits=1 -> credits stays 1.
//   Return at credits==OUT_CREDITS -> o_err_credit=1, credits unchanged.
// 4 Hold i_pool_valid low after the last beat, TIMEOUT=64 -> DONE after 64 DRAIN cycles, o_err_timeout=1.
//   Next i_start clears the flag.
// 5 i_rst_n low mid-STREAM at row 10 -> all outputs 0 immediately, credits=OUT_CREDITS.
//   Next i_start -> o_pool_clr for exactly 1 cycle, row/col restart at 0.
// 6 i_start pulsed during STREAM and DRAIN -> ignored, counts unaffected; i_conv_valid in IDLE -> ready=0.

Source files
------------

// File: rtl/pool_ctrl_pkg.sv
// Shared types and default dimensions for the conv1 -> 2x2 max-pool stream controller.
package pool_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        DONE
    } pool_ctrl_state_t;

    localparam int POOL_IN_DIM  = 28;
    localparam int POOL_OUT_DIM = POOL_IN_DIM / 2;
    localparam int POOL_MAPS    = 6;

endpackage

// File: rtl/pool_credit_cnt.sv
// Up/down saturating credit counter for the pooled-output buffer downstream of the pool.
// A take and a give in the same cycle cancel; a give while already full saturates and
// raises a sticky overflow flag. A load restores the full count and clears the flag.
module pool_credit_cnt #(
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_take,
    input  logic          i_give,
    output logic [CW-1:0] o_credits,
    output logic          o_overflow
);

    localparam logic [CW-1:0] FULL = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] credits_q, credits_d;
    logic          ovf_q, ovf_d;

    // Next credit count and overflow flag from load/take/give.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        credits_d = credits_q;
        ovf_d     = ovf_q;
        if (i_load) begin
            credits_d = FULL;
            ovf_d     = 1'b0;
        end else if (i_take && !i_give) begin
            credits_d = credits_q - ONE;
        end else if (i_give && !i_take) begin
            if (credits_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + ONE;
            end
        end
    end

    // Credit and overflow registers; reset leaves the buffer fully available.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q <= FULL;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            credits_q <= credits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_credits  = credits_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/pool_stream_ctrl.sv
// Frame sequencer between the conv1 beat stream and the 2x2 max-pool stage.
// Clears the pool, admits IN_DIM*IN_DIM beats in raster order, holds back window-closing
// beats until a downstream credit is available, then waits for the remaining pooled
// outputs (bounded by TIMEOUT) before pulsing done.
module pool_stream_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter  int IN_DIM      = POOL_IN_DIM,
    parameter  int OUT_CREDITS = 4,
    parameter  int TIMEOUT     = 64,
    localparam int RC_W        = $clog2(IN_DIM),
    localparam int CR_W        = $clog2(OUT_CREDITS + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err_timeout,
    output logic            o_err_credit,
    input  logic            i_conv_valid,
    output logic            o_conv_ready,
    output logic            o_pool_valid,
    output logic            o_pool_clr,
    output logic [RC_W-1:0] o_row,
    output logic [RC_W-1:0] o_col,
    input  logic            i_pool_valid,
    input  logic            i_credit_return,
    output logic [CR_W-1:0] o_credits
);

    localparam int OUT_TOTAL = (IN_DIM / 2) * (IN_DIM / 2);
    localparam int OUT_W     = $clog2(OUT_TOTAL + 1);
    localparam int TMO_W     = $clog2(TIMEOUT);

    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(IN_DIM - 1);
    localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);
    localparam logic [OUT_W-1:0] OUT_FINAL = OUT_W'(OUT_TOTAL);
    localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    pool_ctrl_state_t state_q, state_d;
    logic [RC_W-1:0]  row_q, row_d, col_q, col_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_tmo_q, err_tmo_d;

    logic producing;
    logic accept;
    logic start_acc;
    logic count_pool;

    // Odd row and odd column: this beat closes a 2x2 window and will yield a pooled vector.
    assign producing  = row_q[0] & col_q[0];
    assign o_conv_ready = (state_q == STREAM) & (~producing | (o_credits != '0));
    assign accept     = i_conv_valid & o_conv_ready;
    assign start_acc  = (state_q == IDLE) & i_start;
    assign count_pool = (state_q != IDLE) && (state_q != CLR);

    // Credits are reserved when a producing beat is accepted, one cycle ahead of its pool result.
    pool_credit_cnt #(
        .MAX_CREDITS (OUT_CREDITS)
    ) u_credit (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (start_acc),
        .i_take     (accept & producing),
        .i_give     (i_credit_return),
        .o_credits  (o_credits),
        .o_overflow (o_err_credit)
    );

    // Frame FSM next state plus raster, output and drain-timeout counters.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        out_cnt_d = out_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        err_tmo_d = err_tmo_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = CLR;
                    row_d     = '0;
                    col_d     = '0;
                    out_cnt_d = '0;
                    err_tmo_d = 1'b0;
                end
            end
            CLR: state_d = STREAM;
            STREAM: begin
                if (accept) begin
                    if (col_q == RC_LAST) begin
                        col_d = '0;
                        if (row_q == RC_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + RC_ONE;
                        end
                    end else begin
                        col_d = col_q + RC_ONE;
                    end
                end
            end
            DRAIN: begin
                // The pooled output arriving this cycle already counts toward completion.
                if ((out_cnt_q + OUT_W'(i_pool_valid)) == OUT_FINAL) begin
                    state_d = DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = DONE;
                    err_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (count_pool && i_pool_valid) begin
            out_cnt_d = out_cnt_q + OUT_ONE;
        end
        if (state_q != DRAIN) begin
            tmo_cnt_d = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            out_cnt_q <= '0;
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_cnt_q <= out_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);
    assign o_pool_clr    = (state_q == CLR);
    assign o_pool_valid  = accept;
    assign o_err_timeout = err_tmo_q;
    assign o_row         = row_q;
    assign o_col         = col_q;

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Directed bench for pool_stream_ctrl: full frames, credit stalls, credit overflow,
// drain timeout, mid-frame reset and ignored starts. Instance a uses 4 credits,
// instance b uses 2 credits.
module tb_pool_stream_ctrl;

    localparam int IN_DIM = 28;
    localparam int BEATS  = IN_DIM * IN_DIM;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Instance a (OUT_CREDITS = 4)
    logic       start, conv_valid, pv_in, credit_ret;
    logic       busy, done, err_tmo, err_cred, conv_ready, pool_valid, pool_clr;
    logic [4:0] row, col;
    logic [2:0] credits;

    // Instance b (OUT_CREDITS = 2)
    logic       b_start, b_conv_valid, b_pv_in, b_credit_ret;
    logic       b_busy, b_done, b_err_tmo, b_err_cred, b_conv_ready, b_pool_valid, b_pool_clr;
    logic [4:0] b_row, b_col;
    logic [1:0] b_credits;

    pool_stream_ctrl #(.IN_DIM(IN_DIM), .OUT_CREDITS(4), .TIMEOUT(64)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .o_busy          (busy),
        .o_done          (done),
        .o_err_timeout   (err_tmo),
        .o_err_credit    (err_cred),
        .i_conv_valid    (conv_valid),
        .o_conv_ready    (conv_ready),
        .o_pool_valid    (pool_valid),
        .o_pool_clr      (pool_clr),
        .o_row           (row),
        .o_col           (col),
        .i_pool_valid    (pv_in),
        .i_credit_return (credit_ret),
        .o_credits       (credits)
    );

    pool_stream_ctrl #(.IN_DIM(IN_DIM), .OUT_CREDITS(2), .TIMEOUT(64)) dut_b (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (b_start),
        .o_busy          (b_busy),
        .o_done          (b_done),
        .o_err_timeout   (b_err_tmo),
        .o_err_credit    (b_err_cred),
        .i_conv_valid    (b_conv_valid),
        .o_conv_ready    (b_conv_ready),
        .o_pool_valid    (b_pool_valid),
        .o_pool_clr      (b_pool_clr),
        .o_row           (b_row),
        .o_col           (b_col),
        .i_pool_valid    (b_pv_in),
        .i_credit_return (b_credit_ret),
        .o_credits       (b_credits)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-run observations
    int r_acc, r_pv, r_last_pv_cyc, r_last_acc_cyc, r_done_cyc;
    int r_err_seen, r_rc_bad, r_clr_seen, r_bound_hit, r_tmo_at_done;

    // Credit-stall observations on instance b
    int n_prod, stalled;
    int prod_row [4];
    int prod_col [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE on instance a, check the CLR cycle and the first STREAM cycle.
    task automatic start_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check({tag, "_clr"},      32'(pool_clr),   1);
        check({tag, "_clr_busy"}, 32'(busy),       1);
        check({tag, "_clr_rdy"},  32'(conv_ready), 0);
        check({tag, "_err_tmo"},  32'(err_tmo),    0);
        check({tag, "_err_cred"}, 32'(err_cred),   0);
        tick();
        check({tag, "_clr_once"}, 32'(pool_clr),   0);
        check({tag, "_row0"},     32'(row),        0);
        check({tag, "_col0"},     32'(col),        0);
        check({tag, "_rdy"},      32'(conv_ready), 1);
    endtask

    // Stream a frame on instance a with conv valid held high. Models the pool (result one
    // cycle after a window-closing accept) and downstream (credit back two cycles after use).
    // Stops at done, after stop_acc accepts (if nonzero), or at a cycle bound.
    task automatic run_frame(input bit gen_pv, input int stop_acc, input bit poke_start);
        bit         pv_next, prod;
        logic [1:0] ret_sh;
        int         cyc, er, ec;
        pv_next = 1'b0;
        ret_sh  = 2'b00;
        cyc     = 0;
        r_acc = 0; r_pv = 0; r_last_pv_cyc = -1; r_last_acc_cyc = -1; r_done_cyc = -1;
        r_err_seen = 0; r_rc_bad = 0; r_clr_seen = 0; r_bound_hit = 0; r_tmo_at_done = 0;
        conv_valid = 1'b1;
        forever begin
            if (cyc >= 3000) begin
                r_bound_hit = 1;
                break;
            end
            pv_in      = gen_pv & pv_next;
            credit_ret = ret_sh[0];
            start      = poke_start && (cyc == 100 || r_acc == BEATS);
            #1;
            if (done) begin
                r_done_cyc    = cyc;
                r_tmo_at_done = int'(err_tmo);
                break;
            end
            if (pool_clr) r_clr_seen++;
            if (err_tmo || err_cred) r_err_seen++;
            prod = 1'b0;
            if (pool_valid) begin
                er = r_acc / IN_DIM;
                ec = r_acc % IN_DIM;
                if (int'(row) != er || int'(col) != ec) r_rc_bad++;
                prod           = er[0] & ec[0];
                r_last_acc_cyc = cyc;
                r_acc++;
            end
            if (pv_in) begin
                r_pv++;
                r_last_pv_cyc = cyc;
            end
            tick();
            pv_next = prod;
            ret_sh  = {prod, ret_sh[1]};
            cyc++;
            if (stop_acc > 0 && r_acc == stop_acc) break;
        end
        if (r_done_cyc >= 0) begin
            // Let the DONE-cycle inputs land before going quiet.
            tick();
            conv_valid = 1'b0;
        end
        pv_in      = 1'b0;
        credit_ret = 1'b0;
        start      = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 0; conv_valid = 0; pv_in = 0; credit_ret = 0;
        b_start = 0; b_conv_valid = 0; b_pv_in = 0; b_credit_ret = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_busy",     32'(busy),       0);
        check("rst_done",     32'(done),       0);
        check("rst_err_tmo",  32'(err_tmo),    0);
        check("rst_err_cred", 32'(err_cred),   0);
        check("rst_ready",    32'(conv_ready), 0);
        check("rst_pool_vld", 32'(pool_valid), 0);
        check("rst_pool_clr", 32'(pool_clr),   0);
        check("rst_row",      32'(row),        0);
        check("rst_col",      32'(col),        0);
        check("rst_credits",  32'(credits),    4);
        check("rst_b_credits", 32'(b_credits), 2);

        // Conv valid in IDLE is never accepted
        tick();
        conv_valid = 1'b1;
        #1;
        check("t6_idle_ready",   32'(conv_ready), 0);
        check("t6_idle_pool_vld", 32'(pool_valid), 0);
        tick();
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_col",  32'(col),  0);
        conv_valid = 1'b0;

        // Full frame with 4 credits, returns two cycles after use
        start_frame("t1");
        run_frame(1'b1, 0, 1'b0);
        check("t1_bound",     32'(r_bound_hit), 0);
        check("t1_accepts",   32'(r_acc),       BEATS);
        check("t1_pool_vlds", 32'(r_pv),        196);
        check("t1_done_gap",  32'(r_done_cyc - r_last_pv_cyc), 1);
        check("t1_err_seen",  32'(r_err_seen),  0);
        check("t1_rowcol",    32'(r_rc_bad),    0);
        check("t1_done_pulse", 32'(done),       0);
        check("t1_idle_busy", 32'(busy),        0);
        check("t1_credits",   32'(credits),     4);
        check("t1_err_tmo",   32'(err_tmo),     0);
        check("t1_err_cred",  32'(err_cred),    0);

        // Credit stall with 2 credits and no returns (instance b)
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        b_conv_valid = 1'b1;
        n_prod  = 0;
        stalled = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!b_conv_ready) begin
                stalled = 1;
                break;
            end
            if (b_row[0] & b_col[0]) begin
                if (n_prod < 4) begin
                    prod_row[n_prod] = int'(b_row);
                    prod_col[n_prod] = int'(b_col);
                end
                n_prod++;
            end
            tick();
        end
        check("t2_stalled",   32'(stalled),     1);
        check("t2_n_prod",    32'(n_prod),      2);
        check("t2_p0_row",    32'(prod_row[0]), 1);
        check("t2_p0_col",    32'(prod_col[0]), 1);
        check("t2_p1_row",    32'(prod_row[1]), 1);
        check("t2_p1_col",    32'(prod_col[1]), 3);
        check("t2_stall_row", 32'(b_row),       1);
        check("t2_stall_col", 32'(b_col),       5);
        check("t2_stall_cr",  32'(b_credits),   0);
        tick();
        tick();
        check("t2_hold_ready", 32'(b_conv_ready), 0);
        b_credit_ret = 1'b1;
        #1;
        check("t2_ret_cycle_ready", 32'(b_conv_ready), 0);
        tick();
        b_credit_ret = 1'b0;
        #1;
        check("t2_after_ret_ready", 32'(b_conv_ready), 1);
        check("t2_after_ret_pv",    32'(b_pool_valid), 1);
        check("t2_after_ret_cr",    32'(b_credits),    1);
        tick();
        tick();
        check("t2_col7",       32'(b_col),        7);
        check("t2_col7_ready", 32'(b_conv_ready), 0);
        check("t2_col7_cr",    32'(b_credits),    0);

        // Same-cycle take and return, then overflow at full credits
        b_credit_ret = 1'b1;
        tick();
        check("t3_pre_cr",    32'(b_credits),    1);
        check("t3_pre_ready", 32'(b_conv_ready), 1);
        tick();
        b_credit_ret = 1'b0;
        b_conv_valid = 1'b0;
        #1;
        check("t3_same_cycle_cr", 32'(b_credits),  1);
        check("t3_col8",          32'(b_col),      8);
        check("t3_no_err",        32'(b_err_cred), 0);
        b_credit_ret = 1'b1;
        tick();
        check("t3_full_cr",  32'(b_credits),  2);
        check("t3_full_err", 32'(b_err_cred), 0);
        tick();
        b_credit_ret = 1'b0;
        #1;
        check("t3_ovf_cr",  32'(b_credits),  2);
        check("t3_ovf_err", 32'(b_err_cred), 1);

        // Drain timeout: pool never reports outputs
        start_frame("t4");
        run_frame(1'b0, 0, 1'b0);
        check("t4_bound",     32'(r_bound_hit), 0);
        check("t4_accepts",   32'(r_acc),       BEATS);
        check("t4_pool_vlds", 32'(r_pv),        0);
        check("t4_drain_len", 32'(r_done_cyc - r_last_acc_cyc), 65);
        check("t4_tmo_flag",  32'(r_tmo_at_done), 1);
        check("t4_tmo_sticky", 32'(err_tmo),    1);
        check("t4_idle",      32'(busy),        0);
        start_frame("t4r");

        // Mid-frame reset at row 10
        run_frame(1'b1, 10 * IN_DIM + 3, 1'b0);
        check("t5_row", 32'(row),  10);
        check("t5_col", 32'(col),  3);
        check("t5_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",     32'(busy),       0);
        check("t5_rst_done",     32'(done),       0);
        check("t5_rst_clr",      32'(pool_clr),   0);
        check("t5_rst_ready",    32'(conv_ready), 0);
        check("t5_rst_pool_vld", 32'(pool_valid), 0);
        check("t5_rst_row",      32'(row),        0);
        check("t5_rst_col",      32'(col),        0);
        check("t5_rst_credits",  32'(credits),    4);
        check("t5_rst_err_tmo",  32'(err_tmo),    0);
        check("t5_rst_err_cred", 32'(err_cred),   0);
        conv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_frame("t5r");

        // Starts pulsed during STREAM and DRAIN are ignored
        run_frame(1'b1, 0, 1'b1);
        check("t6_bound",     32'(r_bound_hit), 0);
        check("t6_accepts",   32'(r_acc),       BEATS);
        check("t6_pool_vlds", 32'(r_pv),        196);
        check("t6_no_clr",    32'(r_clr_seen),  0);
        check("t6_done_gap",  32'(r_done_cyc - r_last_pv_cyc), 1);
        check("t6_rowcol",    32'(r_rc_bad),    0);
        check("t6_idle",      32'(busy),        0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
